// File: rtl/dual_ad_capture_ctrl_if.sv
// Ready/valid sample stream from the dual ADC capture sequencer.
// Carries one channel beat per transfer, with channel id, OTR and last flags.
interface dual_ad_capture_ctrl_if #(
   parameter int DW = 10
);
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          m_ch;
   logic          m_otr;
   logic          m_last;

   modport master (
      output m_valid, m_data, m_ch, m_otr, m_last,
      input  m_ready
   );

   modport slave (
      input  m_valid, m_data, m_ch, m_otr, m_last,
      output m_ready
   );
endinterface

// File: rtl/dual_ad_capture_ctrl.sv
// Dual ADC trigger/capture sequencer: arm, trigger, decimated pair capture, serialised stream.
// Optional macro DUAL_AD_OTR_CLAMP_EN clamps out-of-range samples to full scale.
module dual_ad_capture_ctrl #(
   parameter int DW    = 10,
   parameter int DECIM = 4,
   parameter int LEN_W = 16
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic [DW-1:0]    ad_data_1,
   input  logic [DW-1:0]    ad_data_2,
   input  logic             ad_otr_1,
   input  logic             ad_otr_2,
   input  logic             arm,
   input  logic             abort,
   input  logic             trig_sel,
   input  logic [1:0]       trig_mode,
   input  logic [DW-1:0]    trig_level,
   input  logic [LEN_W-1:0] cap_len,
   output logic             busy,
   output logic             armed,
   output logic             done,
   output logic             overrun,
   dual_ad_capture_ctrl_if.master m_if
);
   localparam int DCW = $clog2(DECIM);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARM,
      S_CAP,
      S_DRAIN
   } state_t;

   state_t           r_state;
   logic [DW-1:0]    r_d1, r_d2, r_d1_p, r_d2_p;
   logic             r_o1, r_o2;
   logic             r_sel;
   logic [1:0]       r_mode;
   logic [DW-1:0]    r_level;
   logic [LEN_W-1:0] r_len, r_cnt;
   logic [DCW-1:0]   r_dec;
   logic             r_valid, r_ch, r_otr, r_last;
   logic [DW-1:0]    r_data, r_h2;
   logic             r_h2_otr, r_h2_last;
   logic             r_done, r_ovr;

   logic [DW-1:0]    w_cur, w_prev, w_s1, w_s2;
   logic             w_rise, w_fall, w_trig;
   logic             w_acc, w_free, w_tick, w_load;
   logic             w_final, w_ovr_hit;
   logic [LEN_W-1:0] w_cnt_nx;

   assign w_cur  = r_sel ? r_d2 : r_d1;
   assign w_prev = r_sel ? r_d2_p : r_d1_p;
   assign w_rise = (w_prev < r_level) && (w_cur >= r_level);
   assign w_fall = (w_prev >= r_level) && (w_cur < r_level);

   always_comb begin
      w_trig = 1'b0;
      unique case (r_mode)
         2'b00:   w_trig = 1'b1;
         2'b01:   w_trig = w_rise;
         2'b10:   w_trig = w_fall;
         default: w_trig = w_rise | w_fall;
      endcase
   end

`ifdef DUAL_AD_OTR_CLAMP_EN
   assign w_s1 = r_o1 ? {DW{r_d1[DW-1]}} : r_d1;
   assign w_s2 = r_o2 ? {DW{r_d2[DW-1]}} : r_d2;
`else
   assign w_s1 = r_d1;
   assign w_s2 = r_d2;
`endif

   // Holding register is free when empty or its ch2 beat leaves this cycle
   assign w_acc     = r_valid && m_if.m_ready;
   assign w_free    = !r_valid || (w_acc && r_ch);
   assign w_tick    = (r_state == S_CAP) && (r_dec == DCW'(DECIM - 1));
   assign w_load    = ((r_state == S_ARM) && w_trig) || (w_tick && w_free);
   assign w_cnt_nx  = (r_state == S_ARM) ? LEN_W'(1) : r_cnt + 1'b1;
   assign w_final   = (w_cnt_nx == r_len);
   assign w_ovr_hit = w_tick && !w_free;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state   <= S_IDLE;
         r_d1      <= '0;
         r_d2      <= '0;
         r_d1_p    <= '0;
         r_d2_p    <= '0;
         r_o1      <= 1'b0;
         r_o2      <= 1'b0;
         r_sel     <= 1'b0;
         r_mode    <= 2'b00;
         r_level   <= '0;
         r_len     <= '0;
         r_cnt     <= '0;
         r_dec     <= '0;
         r_valid   <= 1'b0;
         r_ch      <= 1'b0;
         r_otr     <= 1'b0;
         r_last    <= 1'b0;
         r_data    <= '0;
         r_h2      <= '0;
         r_h2_otr  <= 1'b0;
         r_h2_last <= 1'b0;
         r_done    <= 1'b0;
         r_ovr     <= 1'b0;
      end else begin
         r_d1   <= ad_data_1;
         r_d2   <= ad_data_2;
         r_o1   <= ad_otr_1;
         r_o2   <= ad_otr_2;
         r_d1_p <= r_d1;
         r_d2_p <= r_d2;
         r_done <= 1'b0;
         if (abort) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_ch    <= 1'b0;
            r_last  <= 1'b0;
            r_cnt   <= '0;
            r_dec   <= '0;
         end else begin
            if (w_load) begin
               r_valid   <= 1'b1;
               r_data    <= w_s1;
               r_ch      <= 1'b0;
               r_otr     <= r_o1;
               r_last    <= 1'b0;
               r_h2      <= w_s2;
               r_h2_otr  <= r_o2;
               r_h2_last <= w_final;
               r_cnt     <= w_cnt_nx;
            end else if (w_acc) begin
               if (!r_ch) begin
                  r_ch   <= 1'b1;
                  r_data <= r_h2;
                  r_otr  <= r_h2_otr;
                  r_last <= r_h2_last;
               end else begin
                  r_valid <= 1'b0;
                  r_ch    <= 1'b0;
                  r_last  <= 1'b0;
               end
            end
            if (w_ovr_hit) r_ovr <= 1'b1;
            unique case (r_state)
               S_IDLE: begin
                  if (arm) begin
                     r_sel   <= trig_sel;
                     r_mode  <= trig_mode;
                     r_level <= trig_level;
                     r_len   <= (cap_len == '0) ? LEN_W'(1) : cap_len;
                     r_cnt   <= '0;
                     r_ovr   <= 1'b0;
                     r_state <= S_ARM;
                  end
               end
               S_ARM: begin
                  if (w_trig) begin
                     r_dec   <= '0;
                     r_state <= w_final ? S_DRAIN : S_CAP;
                  end
               end
               S_CAP: begin
                  r_dec <= w_tick ? '0 : r_dec + 1'b1;
                  if (w_load && w_final) r_state <= S_DRAIN;
               end
               S_DRAIN: begin
                  if (w_acc && r_ch && r_last) begin
                     r_state <= S_IDLE;
                     r_done  <= 1'b1;
                     r_cnt   <= '0;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign busy    = (r_state != S_IDLE);
   assign armed   = (r_state == S_ARM);
   assign done    = r_done;
   assign overrun = r_ovr;

   assign m_if.m_valid = r_valid;
   assign m_if.m_data  = r_data;
   assign m_if.m_ch    = r_ch;
   assign m_if.m_otr   = r_otr;
   assign m_if.m_last  = r_last;
endmodule

// File: tb/tb_dual_ad_capture_ctrl.sv
// Scoreboard bench for dual_ad_capture_ctrl: per-run stimulus tables, pair-level model.
// Expected beats are queued before each run and popped by an independent monitor.
module tb_dual_ad_capture_ctrl;
   localparam int DW = 10;
   localparam int D  = 4;
   localparam int LW = 16;
   localparam int NC = 300;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] ad1 = '0, ad2 = '0;
   logic          otr1 = 1'b0, otr2 = 1'b0;
   logic          arm = 1'b0, abort = 1'b0, tsel = 1'b0;
   logic [1:0]    tmode = 2'b00;
   logic [DW-1:0] tlev = '0;
   logic [LW-1:0] clen = '0;
   logic          busy, armed, done, ovr;

   dual_ad_capture_ctrl_if #(.DW(DW)) sif();

   dual_ad_capture_ctrl #(.DW(DW), .DECIM(D), .LEN_W(LW)) dut (
      .sys_clk    (clk),
      .sys_rst_n  (rst_n),
      .ad_data_1  (ad1),
      .ad_data_2  (ad2),
      .ad_otr_1   (otr1),
      .ad_otr_2   (otr2),
      .arm        (arm),
      .abort      (abort),
      .trig_sel   (tsel),
      .trig_mode  (tmode),
      .trig_level (tlev),
      .cap_len    (clen),
      .busy       (busy),
      .armed      (armed),
      .done       (done),
      .overrun    (ovr),
      .m_if       (sif)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          ch;
      logic          otr;
      logic          last;
   } beat_t;

   beat_t         expq[$];
   logic [DW-1:0] p1[NC], p2[NC];
   bit            q1[NC], q2[NC], rdy[NC];
   int            checks = 0, errors = 0;
   int            done_abs = -1;
   bit            exp_ovr = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic bit trig_ok(int mode, int prv, int cur, int lev);
      bit r, f;
      r = (prv < lev) && (cur >= lev);
      f = (prv >= lev) && (cur < lev);
      case (mode)
         0:       return 1'b1;
         1:       return r;
         2:       return f;
         default: return r || f;
      endcase
   endfunction

   function automatic int next_rdy(int x);
      for (int e = x + 1; e < NC; e++) if (rdy[e]) return e;
      return NC + 1000;
   endfunction

   function automatic logic [DW-1:0] sample(logic [DW-1:0] d, bit o);
      logic [DW-1:0] r;
      r = d;
`ifdef DUAL_AD_OTR_CLAMP_EN
      if (o) r = d[DW-1] ? 10'h3FF : 10'h000;
`else
      if (o) r = d;
`endif
      return r;
   endfunction

   // Pair-level model: edge k of a run samples table entry k; arm at k=2
   task automatic model_run(input bit sel, input int mode, input int lev,
                            input int len_in, input int ak, input int base);
      int len, t, l, e1, e2, cnt;
      beat_t b;
      len = (len_in == 0) ? 1 : len_in;
      exp_ovr = 1'b0;
      done_abs = -1;
      t = -1;
      for (int k = 3; k < NC && k < ak; k++) begin
         if (trig_ok(mode, sel ? p2[k-2] : p1[k-2],
                     sel ? p2[k-1] : p1[k-1], lev)) begin
            t = k;
            break;
         end
      end
      if (t < 0) return;
      l = t;
      cnt = 1;
      forever begin
         e1 = next_rdy(l);
         e2 = next_rdy(e1);
         if (cnt < len && l + D < e2 && l + D < ak) exp_ovr = 1'b1;
         if (e1 <= ak) begin
            b = '{sample(p1[l-1], q1[l-1]), 1'b0, q1[l-1], 1'b0};
            expq.push_back(b);
         end
         if (e2 <= ak) begin
            b = '{sample(p2[l-1], q2[l-1]), 1'b1, q2[l-1], cnt == len};
            expq.push_back(b);
         end
         if (e2 > ak) return;
         if (cnt == len) begin
            if (e2 < ak) done_abs = base + e2;
            return;
         end
         l = t + D * ((e2 - t + D - 1) / D);
         if (l >= ak) return;
         cnt++;
      end
   endtask

   task automatic fill(input bit rr);
      for (int k = 0; k < NC; k++) begin
         p1[k]  = DW'($urandom);
         p2[k]  = DW'($urandom);
         q1[k]  = ($urandom_range(0, 7) == 0);
         q2[k]  = ($urandom_range(0, 7) == 0);
         rdy[k] = rr ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   endtask

   // Called at a negedge; plays table entry k into edge base+k
   task automatic play(input bit sel, input int mode, input int lev,
                       input int len, input int ak);
      int base;
      base  = cyc + 1;
      tsel  = sel;
      tmode = 2'(mode);
      tlev  = DW'(lev);
      clen  = LW'(len);
      model_run(sel, mode, lev, len, ak, base);
      for (int k = 0; k < NC; k++) begin
         ad1 = p1[k];
         ad2 = p2[k];
         otr1 = q1[k];
         otr2 = q2[k];
         sif.m_ready = rdy[k];
         arm = (k == 2);
         abort = (k == ak);
         if (k == 3 && ak > 2) begin
            chk("armed_after_arm", int'(armed), 1);
            chk("overrun_cleared_by_arm", int'(ovr), 0);
         end
         if (k == ak + 1) begin
            chk("busy_after_abort", int'(busy), 0);
            chk("valid_after_abort", int'(sif.m_valid), 0);
         end
         @(negedge clk);
      end
      arm = 1'b0;
      abort = 1'b0;
      chk("beats_left_in_queue", expq.size(), 0);
      expq.delete();
   endtask

   beat_t pbeat;
   bit    pstall = 1'b0;

   always @(negedge clk) begin
      beat_t cb, eb;
      bit    ed;
      #1;
      if (rst_n) begin
         cb = '{sif.m_data, sif.m_ch, sif.m_otr, sif.m_last};
         if (pstall) begin
            checks++;
            if (!sif.m_valid || cb != pbeat) begin
               errors++;
               $display("FAIL stall_hold actual=%0b/%h required=1/%h",
                        sif.m_valid, cb, pbeat);
            end
         end
         if (sif.m_valid && sif.m_ready) begin
            checks++;
            if (expq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_beat actual=%h required=none", cb);
            end else begin
               eb = expq.pop_front();
               if (cb != eb) begin
                  errors++;
                  $display("FAIL beat actual d=%h ch=%0b otr=%0b last=%0b required d=%h ch=%0b otr=%0b last=%0b",
                           cb.data, cb.ch, cb.otr, cb.last,
                           eb.data, eb.ch, eb.otr, eb.last);
               end
            end
         end
         pstall = sif.m_valid && !sif.m_ready && !abort;
         pbeat = cb;
         ed = (cyc == done_abs);
         if (ed || done) begin
            checks++;
            if (done != ed || (ed && busy)) begin
               errors++;
               $display("FAIL done_pulse actual=%0b busy=%0b required=%0b busy=0",
                        done, busy, ed);
            end
         end
      end
   end

   initial begin
      sif.m_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_armed", int'(armed), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_overrun", int'(ovr), 0);
      chk("rst_valid", int'(sif.m_valid), 0);
      chk("rst_data", int'(sif.m_data), 0);
      chk("rst_ch_otr_last", int'({sif.m_ch, sif.m_otr, sif.m_last}), 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int k = 0; k < NC; k++) begin
         p1[k] = DW'(k);
         p2[k] = DW'(k + 100);
         q1[k] = 1'b0;
         q2[k] = 1'b0;
         rdy[k] = 1'b1;
      end
      play(1'b0, 0, 0, 3, NC - 1);

      fill(1'b0);
      for (int k = 0; k < NC; k++) p2[k] = (k < 10) ? 10'd500 : 10'd520;
      play(1'b1, 1, 512, 2, NC - 1);

      fill(1'b0);
      for (int k = 0; k < NC; k++) p2[k] = (k < 10) ? 10'd520 : 10'd500;
      play(1'b1, 2, 512, 2, NC - 1);

      fill(1'b0);
      for (int k = 4; k < 14; k++) rdy[k] = 1'b0;
      play(1'b0, 0, 0, 4, NC - 1);
      chk("overrun_sticky", int'(ovr), int'(exp_ovr));
      chk("overrun_expected", int'(exp_ovr), 1);

      fill(1'b0);
      play(1'b0, 0, 0, 0, NC - 1);

      fill(1'b0);
      play(1'b0, 0, 0, 5, 10);

      fill(1'b0);
      p1[2] = 10'h2F0;
      q1[2] = 1'b1;
      play(1'b0, 0, 0, 1, NC - 1);

      for (int i = 0; i < 8; i++) begin
         int ak;
         fill(1'b1);
         ak = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 40)) : NC - 1;
         play(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 1023)), int'($urandom_range(0, 5)), ak);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/dual_ad_capture_ctrl.md
# dual_ad_capture_ctrl

Capture sequencer for the two 10-bit high-speed ADC channels. Arms on command, waits for a level-crossing trigger on a selected channel, then samples both channels together every DECIM clocks for a programmed number of sample pairs. Each pair is serialised into one ready/valid stream (channel 1 beat, then channel 2 beat) for the downstream buffer or DDR writer. The block sits between the ADC pins and the capture memory, in the ADC sample clock domain.

## Interface
- DW, 10, ADC sample width
- DECIM, 4, clocks between pair samples; legal range 2..255
- LEN_W, 16, width of pair-count register

- sys_clk  in  1  ADC sample clock, the same clock driven to ad_clk_1/ad_clk_2
- sys_rst_n  in  1  asynchronous, active-low reset
- ad_data_1 / ad_data_2  in  DW  ADC sample, channels 1/2
- ad_otr_1 / ad_otr_2  in  1  out-of-range flag, channels 1/2
- arm  in  1  single-cycle start request
- abort  in  1  single-cycle cancel
- trig_sel  in  1  trigger source: 0 = channel 1, 1 = channel 2
- trig_mode  in  2  00 = immediate, 01 = rising, 10 = falling, 11 = either edge
- trig_level  in  DW  trigger threshold, unsigned
- cap_len  in  LEN_W  pairs to capture; 0 is treated as 1
- busy  out  1  high while state is not IDLE
- armed  out  1  high in ARM
- done  out  1  one-cycle pulse when capture completes
- overrun  out  1  sticky flag; cleared on an accepted arm
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accept
- m_data  out  DW  sample
- m_ch  out  1  0 = channel 1, 1 = channel 2
- m_otr  out  1  OTR flag for the sample
- m_last  out  1  high on the channel-2 beat of the final pair

## Operation
- Input stage: d1_q, d2_q, otr1_q and otr2_q register the pins every cycle. cur = d_q of trig_sel. prev = cur delayed one cycle.
- Trigger conditions:
  - rising: prev < trig_level && cur >= trig_level
  - falling: prev >= trig_level && cur < trig_level
  - immediate: true
- FSM states: IDLE, ARM, CAP, DRAIN.
  - IDLE -> ARM on arm. trig_sel, trig_mode, trig_level and cap_len are latched here. arm is ignored outside IDLE.
  - ARM -> CAP when the trigger condition is true. The pair {d1_q, d2_q} from that same cycle is latched as pair 0, pair_cnt = 1, and dec_cnt restarts.
  - CAP: dec_cnt counts 0..DECIM-1 and wraps. On wrap to 0 a sample tick occurs.
    - Tick with holding register empty: latch the pair and increment pair_cnt.
    - Tick with holding register still occupied: drop the pair, set overrun, leave pair_cnt unchanged.
  - CAP -> DRAIN when pair_cnt == cap_len.
  - DRAIN -> IDLE when the final channel-2 beat is accepted; done pulses in that cycle.
- abort: from any state go to IDLE next cycle. Clear the holding register and m_valid; no done pulse. abort wins over a simultaneous arm.
- Output sequencing: the holding register emits the ch1 beat, then the ch2 beat.
  - m_data, m_ch, m_otr and m_last stay stable while m_valid && !m_ready.
  - The holding register frees on acceptance of the ch2 beat. A tick in that same cycle latches the new pair (no overrun).

## Timing
- Reset values: all outputs 0, state IDLE, all counters 0, input registers 0.
- Pin-to-stream latency in immediate mode: pins at edge E0 are captured to d_q. Arm was accepted earlier, so ARM is active. At E1 the pair is latched and m_valid is high from E1.
- arm at edge A: state is ARM after A. Immediate trigger latches the pair at A+1.
- Ticks in CAP occur every DECIM clocks, measured from the trigger edge.
- With m_ready held high, each pair occupies 2 clocks, so DECIM >= 2 never overruns.
- pair_cnt is LEN_W bits wide. cap_len = 2^LEN_W-1 must complete without wrap.

## Configuration
- DUAL_AD_OTR_CLAMP_EN defined: a sample whose OTR is set is replaced by full scale before latching. If data MSB = 1 it becomes all-ones (10'h3FF); otherwise 0. m_otr still reports 1.
- Undefined: raw ADC data passes unmodified, with m_otr set.
- Trigger evaluation always uses unclamped data.

## Test plan
- Immediate capture: trig_mode = 00, cap_len = 3, DECIM = 4, m_ready = 1, ramp input. Expect 6 beats with m_ch 0,1,0,1,0,1; pairs spaced 4 clocks apart; m_last on beat 6; done one cycle after beat 6; busy low after.
- Rising trigger: trig_sel = 1, level = 512, ch2 steps 500→520. Expect first ch2 beat = 520, with no beats before the crossing; a falling-mode run with 520→500 gives first ch2 beat = 500.
- Backpressure: m_ready = 0 for 10 clocks, DECIM = 4. Expect overrun = 1, held beat stable, exactly cap_len pairs eventually emitted; overrun cleared by the next arm.
- abort during CAP after 2 pairs: expect m_valid = 0 and busy = 0 next cycle with no done pulse; a subsequent arm restarts normally.
- cap_len = 0: expect exactly one pair with m_last on its ch2 beat.
- Clamp: with DUAL_AD_OTR_CLAMP_EN defined, ad_otr_1 = 1 and data 10'h2F0 gives m_data = 10'h3FF with m_otr = 1. Without the macro, m_data = 10'h2F0.
